// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: state encoding, BCD constants, divider sizing and BCD digit increment for stopwatch_core
package stopwatch_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSED = 2'd2} state_t;
  localparam logic [3:0] BCD_NINE = 4'd9;
  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction
  function automatic int presc_width(input int clk_hz, input int tick_hz);
    return $clog2(calc_div(clk_hz, tick_hz));
  endfunction
  function automatic logic [4:0] bcd_digit_inc(input logic [3:0] d, input logic cin);
    return (cin && d == BCD_NINE) ? 5'b1_0000 : {1'b0, d + {3'd0, cin}};
  endfunction
endpackage

// File: rtl/stopwatch_if.sv
// stopwatch_if: raw buttons in (btn_start_stop, btn_clear), status out (running, tick, bcd_count, overflow)
interface stopwatch_if #(parameter int DIGITS = 4);
  logic btn_start_stop;
  logic btn_clear;
  logic running;
  logic tick;
  logic [4*DIGITS-1:0] bcd_count;
  logic overflow;
  modport master (output btn_start_stop, btn_clear, input running, tick, bcd_count, overflow);
  modport slave (input btn_start_stop, btn_clear, output running, tick, bcd_count, overflow);
endinterface

// File: rtl/button_conditioner.sv
// button_conditioner: raw button -> 2-flop sync -> debounce -> one-cycle press pulse (clk, rst_n, raw in; press out)
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  logic [1:0] sync;
  logic level;
  logic level_q;
  logic [CW-1:0] cnt;
  logic diff;
  assign diff = sync[1] != level;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      level <= 1'b0;
      level_q <= 1'b0;
      cnt <= '0;
      press <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      cnt <= (diff && cnt != CNT_MAX) ? cnt + 1'b1 : '0;
      level <= level ^ (diff && cnt == CNT_MAX);
      level_q <= level;
      press <= level && !level_q;
    end
  end
endmodule

// File: rtl/stopwatch_core.sv
// stopwatch_core: button conditioning, tick prescaler, IDLE/RUN/PAUSED FSM and BCD counter (input_clock, input_reset_n, stopwatch_if.slave sw)
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int TICK_HZ = 100,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DIGITS = 4
) (
  input  logic input_clock,
  input  logic input_reset_n,
  stopwatch_if.slave sw
);
  localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
  localparam int PW = presc_width(CLK_HZ, TICK_HZ);
  localparam int W = 4 * DIGITS;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
  state_t state;
  state_t state_n;
  logic [PW-1:0] presc;
  logic [W-1:0] count;
  logic [W-1:0] count_inc;
  logic count_wrap;
  logic running;
  logic tick;
  logic overflow;
  logic ss_press;
  logic clr_press;
  logic wrap_edge;
  logic clear;
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_stop (
    .clk(input_clock), .rst_n(input_reset_n), .raw(sw.btn_start_stop), .press(ss_press)
  );
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk(input_clock), .rst_n(input_reset_n), .raw(sw.btn_clear), .press(clr_press)
  );
  assign wrap_edge = state == RUN && presc == PRESC_MAX;
  assign clear = state == PAUSED && clr_press;
  always_comb begin
    state_n = state == RUN    ? (ss_press ? PAUSED : RUN) :
              state == PAUSED ? (clr_press ? IDLE : ss_press ? RUN : PAUSED) :
                                (ss_press ? RUN : IDLE);
  end
  always_comb begin
    count_wrap = 1'b1;
    count_inc = '0;
    for (int i = 0; i < DIGITS; i++)
      {count_wrap, count_inc[4*i +: 4]} = bcd_digit_inc(count[4*i +: 4], count_wrap);
  end
  always_ff @(posedge input_clock or negedge input_reset_n) begin
    if (!input_reset_n) begin
      state <= IDLE;
      presc <= '0;
      count <= '0;
      running <= 1'b0;
      tick <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      presc <= (state == IDLE && ss_press) || wrap_edge ? '0 :
               state == RUN ? presc + 1'b1 : presc;
      count <= clear ? '0 : wrap_edge ? count_inc : count;
      overflow <= !clear && (overflow || (wrap_edge && count_wrap));
      tick <= wrap_edge;
      running <= state == RUN;
    end
  end
  assign sw.running = running;
  assign sw.tick = tick;
  assign sw.bcd_count = count;
  assign sw.overflow = overflow;
endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: directed self-checking bench for stopwatch_core
module tb_stopwatch_core;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int failures = 0;
  stopwatch_if #(.DIGITS(4)) sw();
  stopwatch_if #(.DIGITS(4)) swf();
  stopwatch_core #(.CLK_HZ(100), .TICK_HZ(10), .DEBOUNCE_CYCLES(4), .DIGITS(4)) dut (
    .input_clock(clk), .input_reset_n(rst_n), .sw(sw.slave)
  );
  stopwatch_core #(.CLK_HZ(20), .TICK_HZ(10), .DEBOUNCE_CYCLES(4), .DIGITS(4)) dut_fast (
    .input_clock(clk), .input_reset_n(rst_n), .sw(swf.slave)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic press(input bit fast, input logic ss, input logic clr);
    if (fast) begin
      swf.btn_start_stop = ss;
      swf.btn_clear = clr;
    end else begin
      sw.btn_start_stop = ss;
      sw.btn_clear = clr;
    end
    step(6);
    swf.btn_start_stop = 1'b0;
    swf.btn_clear = 1'b0;
    sw.btn_start_stop = 1'b0;
    sw.btn_clear = 1'b0;
    step(2);
  endtask
  task automatic wait_tick(input bit fast, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(fast ? swf.tick : sw.tick) && n < 40);
    if (!(fast ? swf.tick : sw.tick)) check({tag, "_timeout"}, 32'(fast ? swf.tick : sw.tick), 1);
  endtask
  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction
  initial begin
    int ticks;
    int first;
    int last;
    int gap_bad;
    int seen;
    sw.btn_start_stop = 1'b0;
    sw.btn_clear = 1'b0;
    swf.btn_start_stop = 1'b0;
    swf.btn_clear = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_running", sw.running, 0);
    check("rst_tick", sw.tick, 0);
    check("rst_count", sw.bcd_count, 16'h0000);
    check("rst_overflow", sw.overflow, 0);
    step(2);
    rst_n = 1'b1;
    step(2);
    sw.btn_start_stop = 1'b1;
    step(3);
    sw.btn_start_stop = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sw.tick || sw.running) seen++;
    end
    check("glitch_activity", seen, 0);
    check("glitch_count", sw.bcd_count, 16'h0000);
    sw.btn_start_stop = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 8) check("running_edge8", sw.running, 0);
      if (i == 9) check("running_edge9", sw.running, 1);
    end
    sw.btn_start_stop = 1'b0;
    ticks = 0;
    first = 0;
    last = 0;
    gap_bad = 0;
    for (int i = 11; i <= 109; i++) begin
      @(negedge clk);
      if (sw.tick) begin
        ticks++;
        if (first == 0) first = i;
        if (last != 0 && i - last != 10) gap_bad++;
        last = i;
      end
    end
    check("tick_count", ticks, 10);
    check("first_tick_edge", first, 18);
    check("tick_spacing", gap_bad, 0);
    check("count_after_100", sw.bcd_count, 16'h0010);
    check("overflow_low", sw.overflow, 0);
    // pause lands on the edge where the prescaler reads 6, leaving it at 7
    wait_tick(0, "sync_tick");
    step(9);
    press(0, 1'b1, 1'b0);
    check("pause_running_lag", sw.running, 1);
    step(1);
    check("paused_running", sw.running, 0);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sw.tick) seen++;
    end
    check("paused_no_tick", seen, 0);
    check("paused_count", sw.bcd_count, 16'h0012);
    press(0, 1'b1, 1'b0);
    check("resume_tick0", sw.tick, 0);
    step(1);
    check("resume_running", sw.running, 1);
    check("resume_tick1", sw.tick, 0);
    step(1);
    check("resume_tick2", sw.tick, 0);
    step(1);
    check("resume_tick3", sw.tick, 1);
    check("resume_count", sw.bcd_count, 16'h0013);
    press(0, 1'b0, 1'b1);
    check("clear_in_run_running", sw.running, 1);
    wait_tick(0, "clear_in_run_tick");
    check("clear_in_run_count", sw.bcd_count, 16'h0014);
    press(0, 1'b1, 1'b0);
    step(1);
    check("pause2_running", sw.running, 0);
    press(0, 1'b1, 1'b1);
    check("both_count", sw.bcd_count, 16'h0000);
    check("both_overflow", sw.overflow, 0);
    step(20);
    check("both_idle_running", sw.running, 0);
    check("both_idle_count", sw.bcd_count, 16'h0000);
    press(1, 1'b1, 1'b0);
    for (int n = 1; n <= 9999; n++) begin
      wait_tick(1, "fast_tick");
      if (n == 9 || n == 10 || n == 99 || n == 100 || n == 1000 || n == 9999)
        check($sformatf("fast_count_%0d", n), swf.bcd_count, to_bcd(n));
    end
    check("pre_wrap_overflow", swf.overflow, 0);
    wait_tick(1, "wrap_tick");
    check("wrap_count", swf.bcd_count, 16'h0000);
    check("wrap_overflow", swf.overflow, 1);
    wait_tick(1, "post_wrap_tick");
    wait_tick(1, "post_wrap_tick");
    check("post_wrap_count", swf.bcd_count, 16'h0002);
    check("overflow_sticky", swf.overflow, 1);
    press(1, 1'b1, 1'b0);
    step(1);
    press(1, 1'b0, 1'b1);
    check("fast_clear_count", swf.bcd_count, 16'h0000);
    check("fast_clear_overflow", swf.overflow, 0);
    check("fast_clear_running", swf.running, 0);
    press(0, 1'b1, 1'b0);
    wait_tick(0, "midrun_tick");
    wait_tick(0, "midrun_tick");
    check("midrun_count", sw.bcd_count, 16'h0002);
    #1 rst_n = 1'b0;
    #1;
    check("async_running", sw.running, 0);
    check("async_tick", sw.tick, 0);
    check("async_count", sw.bcd_count, 16'h0000);
    check("async_overflow", sw.overflow, 0);
    step(3);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (sw.tick || sw.running) seen++;
    end
    check("post_reset_idle", seen, 0);
    check("post_reset_count", sw.bcd_count, 16'h0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
- Timebase and counting stage that feeds the Part4 display/output stage.
- Conditions two raw pushbuttons, divides input_clock down to a count tick, and runs a start/stop/clear state machine.
- Maintains a DIGITS-wide packed BCD count that the downstream stage renders.
- Single clock domain: input_clock.

Parameters:
- CLK_HZ, 50000000, input_clock frequency in Hz.
- TICK_HZ, 100, count rate in Hz. DIV = CLK_HZ/TICK_HZ must be an integer >= 2.
- DEBOUNCE_CYCLES, 1000000, number of stable cycles required to accept a button level (>= 2).
- DIGITS, 4, number of BCD digits.

Ports:
- input_clock  in  1  system clock, rising edge.
- input_reset_n  in  1  asynchronous, active-low reset.
- btn_start_stop  in  1  raw, asynchronous button, active high.
- btn_clear  in  1  raw, asynchronous button, active high.
- running  out  1  high while in RUN.
- tick  out  1  one-cycle pulse, coincident with each count update.
- bcd_count  out  4*DIGITS  packed BCD; digit 0 is bits [3:0] (least significant).
- overflow  out  1  sticky; set when the count wraps from all-9s to zero.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-run):
  - state = IDLE, prescaler = 0.
  - All outputs = 0.
  - Synchronisers, debounced levels and debounce counters = 0.
- Button conditioning, per button:
  - 2-flop synchroniser.
  - Debounce counter: if the synced level differs from the debounced level, the counter increments; otherwise it returns to 0.
  - When the counter = DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level flips and the counter returns to 0.
  - Press pulse is registered on the rising edge of the debounced level.
  - Fixed latency: the FSM acts on the (DEBOUNCE_CYCLES+4)th rising edge after the raw input goes and stays high.
  - Pulses shorter than DEBOUNCE_CYCLES are ignored.
  - Release never produces an action.
  - A button held through reset produces exactly one press after reset deasserts.
- FSM states: IDLE, RUN, PAUSED.
  - IDLE: start_stop -> RUN, and prescaler forced to 0. clear has no effect.
  - RUN: start_stop -> PAUSED. clear is ignored.
  - PAUSED: clear -> IDLE, with bcd_count = 0 and overflow = 0. Otherwise start_stop -> RUN.
  - Both presses in the same cycle: in PAUSED, clear wins; in RUN or IDLE, start_stop acts.
- Prescaler:
  - Counts 0..DIV-1 only in RUN.
  - Holds its value in PAUSED, so a resumed interval continues where it stopped.
- Count:
  - On the edge where prescaler = DIV-1 in RUN: prescaler -> 0, bcd_count increments, and tick is registered high for exactly the next cycle.
  - tick and the new bcd_count are visible in the same cycle.
  - Increment is decimal: digit 9 -> 0 with carry; carry ripples through all digits in that same edge.
  - Each digit is always in 0..9.
  - All-9s wraps to all-0s, sets overflow, and counting continues.
- running is a registered decode of state (RUN), valid the cycle after the transition edge.
- A tick never occurs outside RUN. If a start_stop press to PAUSED coincides with a prescaler wrap, the tick and increment still occur on that edge.

Decomposition:
- Package stopwatch_pkg:
  - 2-bit state encoding: IDLE = 0, RUN = 1, PAUSED = 2.
  - BCD_NINE constant.
  - Function for DIV and prescaler width ($clog2(DIV)).
- Sub-module button_conditioner:
  - Synchroniser + debounce + rising-edge press pulse.
  - Parameter DEBOUNCE_CYCLES.
  - Instantiated twice.
- BCD increment: a combinational function in the package.

Test Plan:
Bench parameters: CLK_HZ = 100, TICK_HZ = 10 (DIV = 10), DEBOUNCE_CYCLES = 4, DIGITS = 4.
1. Reset and glitch: assert input_reset_n = 0, then release; pulse btn_start_stop high for 3 cycles -> bcd_count = 16'h0000, running = 0, tick never, state IDLE.
2. Start and count: hold btn_start_stop high for 10 cycles -> running = 1 on edge 9 after assertion; after 100 further cycles bcd_count = 16'h0010, exactly 10 tick pulses, each 1 cycle wide and 10 cycles apart.
3. Pause/resume: pause when the prescaler = 6, wait 50 cycles (no tick, count frozen), then resume -> first tick exactly 3 RUN cycles after running rises (prescaler 7, 8, 9 -> wrap).
4. Clear rules: press clear in RUN -> ignored, count keeps advancing; pause, then press clear and start_stop in the same cycle -> IDLE, bcd_count = 0, overflow = 0.
5. Wrap: run 9999 ticks -> bcd_count = 16'h9999, overflow = 0; next tick -> 16'h0000, overflow = 1 and stays high while counting continues; clear from PAUSED -> 0.
6. Reset mid-run: drop input_reset_n between edges while counting -> all outputs 0 immediately, without waiting for a clock edge; after release the FSM remains in IDLE.
